seq_adder: RTL and testbench

SEQ_ADDER -- requirements
Module: seq_adder

---
 rtl/seq_adder.sv | 145 ++++++++++++++
 tb/tb_seq_adder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder.sv
// seq_adder: chunked adder summing CHUNK bits per cycle; optional subtract when SEQ_ADDER_SUB_EN is defined.
// Latency: done pulses N = WIDTH/CHUNK cycles after the edge that accepts start; s/cout/ovf update on that edge.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted with no idle gap.
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [CHUNK:0]   chunk_sum;
  logic             carry_msb;

  // Operand B and the initial carry as loaded on an accepted start (inverted B and carry 1 for subtract).
  always_comb begin
    b_in = b;
    c_in = cin;
`ifdef SEQ_ADDER_SUB_EN
    if (sub) begin
      b_in = ~b;
      c_in = 1'b1;
    end
`endif
  end

  // One chunk of the sum; the carry into the chunk's top bit is recovered as s^a^b at that bit.
  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    carry_msb = chunk_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
  end

  // Next-state: IDLE/DONE accept start, RUN consumes one chunk per edge and publishes on the last one.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        res_d   = WIDTH'({chunk_sum[CHUNK-1:0], res_q} >> CHUNK);
        if (cnt_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          s_d     = res_d;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = carry_msb ^ chunk_sum[CHUNK];
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_d     = a;
          b_d     = b_in;
          carry_d = c_in;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // All state, including the registered outputs, with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: 8/2 main instance plus 16/16 and 16/1 instances, scoreboard queue of expected results.
// Expected values come from an independent wide-integer reference model; latency measured in cycles.
// Inputs are driven and outputs sampled on the falling edge.
module tb_seq_adder;

  logic        clk;
  logic        rst_n;

  logic        start8, cin8;
  logic [7:0]  a8, b8, s8;
  logic        busy8, done8, cout8, ovf8;

  logic        start_w, start_n, cin16;
  logic [15:0] a16, b16, s_w, s_n;
  logic        busy_w, done_w, cout_w, ovf_w;
  logic        busy_n, done_n, cout_n, ovf_n;

`ifdef SEQ_ADDER_SUB_EN
  logic        sub8, sub16;
`endif

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  seq_adder #(.WIDTH(8), .CHUNK(2)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  seq_adder #(.WIDTH(16), .CHUNK(16)) u_dw (
    .clk(clk), .rst_n(rst_n), .start(start_w), .a(a16), .b(b16), .cin(cin16),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub16),
`endif
    .busy(busy_w), .done(done_w), .s(s_w), .cout(cout_w), .ovf(ovf_w)
  );

  seq_adder #(.WIDTH(16), .CHUNK(1)) u_dn (
    .clk(clk), .rst_n(rst_n), .start(start_n), .a(a16), .b(b16), .cin(cin16),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub16),
`endif
    .busy(busy_n), .done(done_n), .s(s_n), .cout(cout_n), .ovf(ovf_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  // Reference: w-bit add (or subtract as a + ~b + 1); overflow from operand/result sign rule.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic sub_op);
    logic [16:0] mask, full;
    logic [15:0] am, bb;
    logic        cc;
    exp_t        e;
    mask   = (17'd1 << w) - 17'd1;
    am     = a & mask[15:0];
    bb     = (sub_op ? ~b : b) & mask[15:0];
    cc     = sub_op ? 1'b1 : c;
    full   = {1'b0, am} + {1'b0, bb} + {16'd0, cc};
    e.s    = full[15:0] & mask[15:0];
    e.cout = full[w];
    e.ovf  = (am[w-1] == bb[w-1]) && (e.s[w-1] != am[w-1]);
    return e;
  endfunction

  // Present one operation to the 8-bit instance for one cycle and record its expected result.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub_op);
    a8 = a; b8 = b; cin8 = c;
`ifdef SEQ_ADDER_SUB_EN
    sub8 = sub_op;
`endif
    start8 = 1'b1;
    sb.push_back(model(8, {8'd0, a}, {8'd0, b}, c, sub_op));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Cycles until done is seen on the 8-bit instance; -1 when the bound expires.
  task automatic wait8(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done8 === 1'b1) return;
      if (cyc > 40) begin
        cyc = -1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start_w = 1'b0; start_n = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    sub8 = 1'b0; sub16 = 1'b0;
`endif
    #1;
    nvec++;
    if ({busy8, done8, s8, cout8, ovf8} !== 12'd0) begin
      nerr++; $display("FAIL reset8: got %h want 000", {busy8, done8, s8, cout8, ovf8});
    end
    nvec++;
    if ({busy_w, done_w, s_w, cout_w, ovf_w, busy_n, done_n, s_n, cout_n, ovf_n} !== 40'd0) begin
      nerr++; $display("FAIL reset16: got %h want 0", {busy_w, done_w, s_w, cout_w, ovf_w, busy_n, done_n, s_n, cout_n, ovf_n});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    logic [7:0] va[7] = '{8'hFF, 8'h7F, 8'h80, 8'h00, 8'h3C, 8'hA5, 8'hFF};
    logic [7:0] vb[7] = '{8'h01, 8'h01, 8'h80, 8'h00, 8'h0F, 8'h5A, 8'hFF};
    logic       vc[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_t e;
    int   cyc;
    for (int i = 0; i < 7; i++) begin
      drive8(va[i], vb[i], vc[i], 1'b0);
      nvec++;
      if (busy8 !== 1'b1) begin
        nerr++; $display("FAIL busy_after_start[%0d]: got %b want 1", i, busy8);
      end
      wait8(cyc);
      e = sb.pop_front();
      nvec++;
      if (cyc !== 4) begin
        nerr++; $display("FAIL latency8[%0d]: got %0d want 4", i, cyc);
      end
      nvec++;
      if ({s8, cout8, ovf8} !== {e.s[7:0], e.cout, e.ovf}) begin
        nerr++; $display("FAIL add8[%0d]: got s=%h c=%b v=%b want s=%h c=%b v=%b", i, s8, cout8, ovf8, e.s[7:0], e.cout, e.ovf);
      end
      nvec++;
      if (busy8 !== 1'b0) begin
        nerr++; $display("FAIL busy_at_done[%0d]: got %b want 0", i, busy8);
      end
      @(negedge clk);
      nvec++;
      if ({done8, s8} !== {1'b0, e.s[7:0]}) begin
        nerr++; $display("FAIL pulse_hold[%0d]: got done=%b s=%h want done=0 s=%h", i, done8, s8, e.s[7:0]);
      end
    end
  endtask

  task automatic test_ignore;
    exp_t e;
    int   cyc, extra;
    drive8(8'h10, 8'h20, 1'b0, 1'b0);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(cyc);
    e = sb.pop_front();
    nvec++;
    if (cyc !== 3) begin
      nerr++; $display("FAIL ignore_latency: got %0d want 3", cyc);
    end
    nvec++;
    if ({s8, cout8, ovf8} !== {e.s[7:0], e.cout, e.ovf}) begin
      nerr++; $display("FAIL ignore_result: got s=%h want s=%h", s8, e.s[7:0]);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8 === 1'b1) extra++;
    end
    nvec++;
    if (extra !== 0) begin
      nerr++; $display("FAIL ignore_extra_done: got %0d want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e1, e2;
    int   cyc;
    drive8(8'h55, 8'h22, 1'b1, 1'b0);
    wait8(cyc);
    e1 = sb.pop_front();
    nvec++;
    if ({cyc, s8} !== {32'd4, e1.s[7:0]}) begin
      nerr++; $display("FAIL b2b_first: got cyc=%0d s=%h want cyc=4 s=%h", cyc, s8, e1.s[7:0]);
    end
    drive8(8'hC3, 8'h4D, 1'b0, 1'b0);
    nvec++;
    if ({busy8, done8, s8} !== {2'b10, e1.s[7:0]}) begin
      nerr++; $display("FAIL b2b_gap: got busy=%b done=%b s=%h want busy=1 done=0 s=%h", busy8, done8, s8, e1.s[7:0]);
    end
    wait8(cyc);
    e2 = sb.pop_front();
    nvec++;
    if (cyc !== 4) begin
      nerr++; $display("FAIL b2b_latency: got %0d want 4", cyc);
    end
    nvec++;
    if ({s8, cout8, ovf8} !== {e2.s[7:0], e2.cout, e2.ovf}) begin
      nerr++; $display("FAIL b2b_second: got s=%h c=%b v=%b want s=%h c=%b v=%b", s8, cout8, ovf8, e2.s[7:0], e2.cout, e2.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   cyc;
    drive8(8'h12, 8'h34, 1'b0, 1'b0);
    wait8(cyc);
    e = sb.pop_front();
    nvec++;
    if (s8 !== e.s[7:0]) begin
      nerr++; $display("FAIL pre_reset: got %h want %h", s8, e.s[7:0]);
    end
    @(negedge clk);
    drive8(8'h99, 8'h11, 1'b0, 1'b0);
    e = sb.pop_back();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy8, done8, s8, cout8, ovf8} !== 12'd0) begin
      nerr++; $display("FAIL mid_reset: got %h want 000", {busy8, done8, s8, cout8, ovf8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive8(8'h0F, 8'h01, 1'b1, 1'b0);
    wait8(cyc);
    e = sb.pop_front();
    nvec++;
    if ({cyc, s8, cout8, ovf8} !== {32'd4, e.s[7:0], e.cout, e.ovf}) begin
      nerr++; $display("FAIL post_reset: got cyc=%0d s=%h want cyc=4 s=%h", cyc, s8, e.s[7:0]);
    end
    @(negedge clk);
  endtask

`ifdef SEQ_ADDER_SUB_EN
  task automatic test_sub;
    logic [7:0] va[3] = '{8'h05, 8'h80, 8'h40};
    logic [7:0] vb[3] = '{8'h07, 8'h01, 8'h40};
    exp_t e;
    int   cyc;
    for (int i = 0; i < 3; i++) begin
      drive8(va[i], vb[i], 1'b0, 1'b1);
      wait8(cyc);
      e = sb.pop_front();
      nvec++;
      if ({cyc, s8, cout8, ovf8} !== {32'd4, e.s[7:0], e.cout, e.ovf}) begin
        nerr++; $display("FAIL sub8[%0d]: got cyc=%0d s=%h c=%b v=%b want cyc=4 s=%h c=%b v=%b", i, cyc, s8, cout8, ovf8, e.s[7:0], e.cout, e.ovf);
      end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_wide;
    exp_t e;
    int   cyc;
    for (int i = 0; i < 6; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      if (i == 0) begin a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; end
      start_w = 1'b1;
      sb.push_back(model(16, a16, b16, cin16, 1'b0));
      @(negedge clk);
      start_w = 1'b0;
      cyc = 0;
      while (done_w !== 1'b1 && cyc <= 40) begin
        @(negedge clk);
        cyc++;
      end
      e = sb.pop_front();
      nvec++;
      if ({cyc, s_w, cout_w, ovf_w} !== {32'd1, e.s, e.cout, e.ovf}) begin
        nerr++; $display("FAIL w16c16[%0d]: got cyc=%0d s=%h c=%b v=%b want cyc=1 s=%h c=%b v=%b", i, cyc, s_w, cout_w, ovf_w, e.s, e.cout, e.ovf);
      end
      @(negedge clk);
      start_n = 1'b1;
      sb.push_back(model(16, a16, b16, cin16, 1'b0));
      @(negedge clk);
      start_n = 1'b0;
      cyc = 0;
      while (done_n !== 1'b1 && cyc <= 40) begin
        @(negedge clk);
        cyc++;
      end
      e = sb.pop_front();
      nvec++;
      if ({cyc, s_n, cout_n, ovf_n} !== {32'd16, e.s, e.cout, e.ovf}) begin
        nerr++; $display("FAIL w16c1[%0d]: got cyc=%0d s=%h c=%b v=%b want cyc=16 s=%h c=%b v=%b", i, cyc, s_n, cout_n, ovf_n, e.s, e.cout, e.ovf);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_ADDER_SUB_EN
    test_sub();
`endif
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
